// File: rtl/correction_stream_tx.sv
// correction_stream_tx
// Serialises one decode result into the host byte stream: iteration byte,
// cycle-count high byte, cycle-count low byte, then the correction bitmap
// packed round by round into zero-padded bytes.
// Optional build macro CORRECTION_STREAM_CHECKSUM_EN appends one trailing
// byte holding the XOR of every earlier byte of the message.
module correction_stream_tx #(
  parameter int GRID_WIDTH_X          = 6,
  parameter int GRID_WIDTH_Z          = 3,
  parameter int PHYSICAL_GRID_WIDTH_U = 10,
  parameter int NUM_CONTEXTS          = 1,
  localparam int ROUNDS = PHYSICAL_GRID_WIDTH_U * NUM_CONTEXTS,
  localparam int CPR    = (GRID_WIDTH_X - 1) * GRID_WIDTH_Z * 2 + 1 + GRID_WIDTH_X * GRID_WIDTH_Z,
  localparam int BPR    = (CPR + 7) >> 3,
  localparam int CORR_W = CPR * ROUNDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load_valid,
  output logic              o_load_ready,
  input  logic [31:0]       i_iteration_count,
  input  logic [31:0]       i_cycle_count,
  input  logic [CORR_W-1:0] i_corrections,
  output logic [7:0]        o_output_data,
  output logic              o_output_valid,
  input  logic              i_output_ready,
  output logic              o_busy
);

  // Valid bits in the final byte of each round; the rest of that byte is padding.
  localparam int LAST_BITS = CPR - (BPR - 1) * 8;
  // Eight spare zero bits keep the low byte select legal for tiny grids.
  localparam int SH_W  = CORR_W + 8;
  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int SUB_W = (BPR > 1) ? $clog2(BPR) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_BODY = 2'd2
`ifdef CORRECTION_STREAM_CHECKSUM_EN
    ,
    S_CSUM = 2'd3
`endif
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_hdr_cnt, w_hdr_cnt_nxt;
  logic [RND_W-1:0]  r_round, w_round_nxt;
  logic [SUB_W-1:0]  r_sub, w_sub_nxt;
  logic [7:0]        r_out_data, w_out_data_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic [SH_W-1:0]   r_sh, w_sh_nxt;
  logic [15:0]       r_cyc16, w_cyc16_nxt;
`ifdef CORRECTION_STREAM_CHECKSUM_EN
  logic [7:0]        r_csum, w_csum_nxt;
`endif

  logic              w_xfer;
  logic              w_sub_last;
  logic              w_round_last;
  logic [SUB_W-1:0]  w_sub_adv;
  logic              w_adv_last;
  logic [3:0]        w_shamt;
  logic [SH_W-1:0]   w_sh_step;

  function automatic logic [7:0] sat_iter(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [15:0] sat_cycle(input logic [31:0] v);
    return (v > 32'd65535) ? 16'hFFFF : v[15:0];
  endfunction

  // Clears the bits beyond the round's last correction bit.
  function automatic logic [7:0] pad_byte(input logic [7:0] b, input logic is_last);
    logic [7:0] m;
    for (int t = 0; t < 8; t++) begin
      m[t] = b[t] & (~is_last | (t < LAST_BITS));
    end
    return m;
  endfunction

  assign w_xfer       = r_out_valid & i_output_ready;
  assign w_sub_last   = (r_sub == SUB_W'(BPR - 1));
  assign w_round_last = (r_round == RND_W'(ROUNDS - 1));
  assign w_sub_adv    = w_sub_last ? '0 : r_sub + 1'b1;
  assign w_adv_last   = (w_sub_adv == SUB_W'(BPR - 1));
  // Within a round the window steps a full byte; at the round end it steps
  // only over the remaining real bits so the next round starts at bit 0.
  assign w_shamt      = w_sub_last ? 4'(LAST_BITS) : 4'd8;
  assign w_sh_step    = r_sh >> w_shamt;

  assign o_output_data  = r_out_data;
  assign o_output_valid = r_out_valid;
  assign o_load_ready   = (r_state == S_IDLE);
  assign o_busy         = (r_state != S_IDLE);

  // Next-state and next-byte selection; the byte for the following slot is
  // prepared on each transfer so the output stays a plain register.
  always_comb begin
    w_state_nxt     = r_state;
    w_hdr_cnt_nxt   = r_hdr_cnt;
    w_round_nxt     = r_round;
    w_sub_nxt       = r_sub;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_sh_nxt        = r_sh;
    w_cyc16_nxt     = r_cyc16;
`ifdef CORRECTION_STREAM_CHECKSUM_EN
    w_csum_nxt      = w_xfer ? (r_csum ^ r_out_data) : r_csum;
`endif
    case (r_state)
      S_IDLE: begin
        w_out_valid_nxt = 1'b0;
        if (i_load_valid) begin
          w_state_nxt     = S_HDR;
          w_hdr_cnt_nxt   = 2'd0;
          w_round_nxt     = '0;
          w_sub_nxt       = '0;
          w_sh_nxt        = {8'd0, i_corrections};
          w_cyc16_nxt     = sat_cycle(i_cycle_count);
          w_out_data_nxt  = sat_iter(i_iteration_count);
          w_out_valid_nxt = 1'b1;
`ifdef CORRECTION_STREAM_CHECKSUM_EN
          w_csum_nxt      = 8'd0;
`endif
        end
      end
      S_HDR: begin
        if (w_xfer) begin
          if (r_hdr_cnt == 2'd0) begin
            w_hdr_cnt_nxt  = 2'd1;
            w_out_data_nxt = r_cyc16[15:8];
          end else if (r_hdr_cnt == 2'd1) begin
            w_hdr_cnt_nxt  = 2'd2;
            w_out_data_nxt = r_cyc16[7:0];
          end else begin
            w_state_nxt    = S_BODY;
            w_hdr_cnt_nxt  = 2'd0;
            w_round_nxt    = '0;
            w_sub_nxt      = '0;
            w_out_data_nxt = pad_byte(r_sh[7:0], 1'(BPR == 1));
          end
        end
      end
      S_BODY: begin
        if (w_xfer) begin
          if (w_sub_last && w_round_last) begin
`ifdef CORRECTION_STREAM_CHECKSUM_EN
            w_state_nxt     = S_CSUM;
            w_out_data_nxt  = r_csum ^ r_out_data;
`else
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b0;
`endif
          end else begin
            w_sh_nxt       = w_sh_step;
            w_sub_nxt      = w_sub_adv;
            w_round_nxt    = w_sub_last ? r_round + 1'b1 : r_round;
            w_out_data_nxt = pad_byte(w_sh_step[7:0], w_adv_last);
          end
        end
      end
`ifdef CORRECTION_STREAM_CHECKSUM_EN
      S_CSUM: begin
        if (w_xfer) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
        end
      end
`endif
      default: begin
        w_state_nxt     = S_IDLE;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Control state: FSM, counters and the output register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_hdr_cnt   <= 2'd0;
      r_round     <= '0;
      r_sub       <= '0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hdr_cnt   <= w_hdr_cnt_nxt;
      r_round     <= w_round_nxt;
      r_sub       <= w_sub_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Captured message data; only read while a message is in flight.
  always_ff @(posedge clk) begin
    r_sh    <= w_sh_nxt;
    r_cyc16 <= w_cyc16_nxt;
`ifdef CORRECTION_STREAM_CHECKSUM_EN
    r_csum  <= w_csum_nxt;
`endif
  end

endmodule

// File: tb/tb_correction_stream_tx.sv
// tb_correction_stream_tx
// Directed and randomised messages against a byte-list reference model.
module tb_correction_stream_tx;

  localparam int GX         = 6;
  localparam int GZ         = 3;
  localparam int U          = 10;
  localparam int NC         = 1;
  localparam int ROUNDS     = U * NC;
  localparam int CPR        = (GX - 1) * GZ * 2 + 1 + GX * GZ;
  localparam int BPR        = (CPR + 7) / 8;
  localparam int BODY_BYTES = BPR * ROUNDS;
  localparam int CORR_W     = CPR * ROUNDS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_load_valid = 1'b0;
  logic              o_load_ready;
  logic [31:0]       i_iteration_count = '0;
  logic [31:0]       i_cycle_count = '0;
  logic [CORR_W-1:0] i_corrections = '0;
  logic [7:0]        o_output_data;
  logic              o_output_valid;
  logic              i_output_ready = 1'b1;
  logic              o_busy;

  int n_chk = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  correction_stream_tx #(
    .GRID_WIDTH_X(GX),
    .GRID_WIDTH_Z(GZ),
    .PHYSICAL_GRID_WIDTH_U(U),
    .NUM_CONTEXTS(NC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_load_valid(i_load_valid),
    .o_load_ready(o_load_ready),
    .i_iteration_count(i_iteration_count),
    .i_cycle_count(i_cycle_count),
    .i_corrections(i_corrections),
    .o_output_data(o_output_data),
    .o_output_valid(o_output_valid),
    .i_output_ready(i_output_ready),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return 32'(got_q[i]);
    return 32'hDEAD;
  endfunction

  // Expected message from the byte-layout rules: saturated header, then byte n
  // of the body is round n/BPR, sub-byte n%BPR, zero beyond the round's bits.
  task automatic build_expected(input logic [31:0] it, input logic [31:0] cy,
                                input logic [CORR_W-1:0] c);
    logic [7:0]  ib;
    logic [15:0] cb;
    logic [7:0]  b;
    exp_q.delete();
    ib = (it > 32'd255) ? 8'hFF : it[7:0];
    cb = (cy > 32'd65535) ? 16'hFFFF : cy[15:0];
    exp_q.push_back(ib);
    exp_q.push_back(cb[15:8]);
    exp_q.push_back(cb[7:0]);
    for (int n = 0; n < BODY_BYTES; n++) begin
      int r;
      int s;
      r = n / BPR;
      s = n % BPR;
      b = 8'd0;
      for (int t = 0; t < 8; t++) begin
        if (s * 8 + t < CPR) b[t] = c[r * CPR + s * 8 + t];
      end
      exp_q.push_back(b);
    end
`ifdef CORRECTION_STREAM_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'd0;
      foreach (exp_q[i]) x ^= exp_q[i];
      exp_q.push_back(x);
    end
`endif
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_load(input string tag, input logic [31:0] it, input logic [31:0] cy,
                         input logic [CORR_W-1:0] c);
    build_expected(it, cy, c);
    i_iteration_count = it;
    i_cycle_count     = cy;
    i_corrections     = c;
    i_load_valid      = 1'b1;
    chk({tag, "_load_ready"}, 32'(o_load_ready), 32'd1);
    @(negedge clk);
    i_load_valid      = 1'b0;
    i_iteration_count = $urandom;
    i_cycle_count     = $urandom;
    i_corrections     = ~c;
  endtask

  // Drains the stream into got_q. rnd: random backpressure. stop_after > 0
  // returns once that many bytes are committed. pulse_at >= 0 raises a stray
  // load_valid with fresh data on that cycle of the message.
  task automatic collect(input string tag, input bit rnd, input int stop_after,
                         input int pulse_at);
    int   cyc;
    bit   stalled;
    bit   done;
    logic rdy;
    logic [7:0] pd;
    got_q.delete();
    stalled = 1'b0;
    done    = 1'b0;
    pd      = 8'd0;
    cyc     = 0;
    chk({tag, "_first_valid"}, 32'(o_output_valid), 32'd1);
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    chk({tag, "_ready_low"}, 32'(o_load_ready), 32'd0);
    while (!done && cyc < 2000) begin
      i_load_valid = 1'b0;
      if (cyc == pulse_at) begin
        i_load_valid      = 1'b1;
        i_iteration_count = 32'd99;
        i_cycle_count     = 32'h0000_BEEF;
        i_corrections     = '1;
      end
      if (stalled) begin
        chk({tag, "_stall_valid"}, 32'(o_output_valid), 32'd1);
        chk({tag, "_stall_data"}, 32'(o_output_data), 32'(pd));
      end
      if (!o_output_valid) begin
        done = 1'b1;
      end else begin
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        i_output_ready = rdy;
        if (rdy) got_q.push_back(o_output_data);
        stalled = !rdy;
        pd      = o_output_data;
        if (stop_after > 0 && got_q.size() == stop_after) begin
          done = 1'b1;
        end else begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    i_output_ready = 1'b1;
    if (stop_after == 0) begin
      chk({tag, "_end_load_ready"}, 32'(o_load_ready), 32'd1);
      chk({tag, "_end_busy"}, 32'(o_busy), 32'd0);
    end
  endtask

  task automatic compare_msg(input string tag, input int upto);
    int n;
    n = (upto > 0) ? upto : exp_q.size();
    if (upto == 0) chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), got_at(i), 32'(exp_q[i]));
    end
  endtask

  initial begin
    logic [CORR_W-1:0] cv;
    logic [31:0] it;
    logic [31:0] cy;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(o_output_valid), 32'd0);
    chk("rst_data", 32'(o_output_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_load_ready", 32'(o_load_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(o_output_valid), 32'd0);

    // basic message, no stalls
    do_load("basic", 32'd5, 32'h0000_0123, '0);
    collect("basic", 1'b0, 0, -1);
    compare_msg("basic", 0);
    chk("basic_b0", got_at(0), 32'h05);
    chk("basic_b1", got_at(1), 32'h01);
    chk("basic_b2", got_at(2), 32'h23);
    chk("basic_b40", got_at(40), 32'h00);
`ifdef CORRECTION_STREAM_CHECKSUM_EN
    chk("basic_csum", got_at(73), 32'h27);
`endif

    // bit packing, loaded back-to-back in the gap cycle
    cv = '0;
    cv[0]   = 1'b1;
    cv[48]  = 1'b1;
    cv[49]  = 1'b1;
    cv[489] = 1'b1;
    do_load("pack", 32'd7, 32'd16, cv);
    collect("pack", 1'b0, 0, -1);
    compare_msg("pack", 0);
    chk("pack_body0", got_at(3), 32'h01);
    chk("pack_body6", got_at(9), 32'h01);
    chk("pack_body7", got_at(10), 32'h01);
    chk("pack_body69", got_at(72), 32'h01);
    chk("pack_body1", got_at(4), 32'h00);

    // saturation
    repeat (3) @(negedge clk);
    for (int i = 0; i < CORR_W; i++) cv[i] = 1'($urandom_range(0, 1));
    do_load("sat", 32'd300, 32'h0001_2345, cv);
    collect("sat", 1'b0, 0, -1);
    compare_msg("sat", 0);
    chk("sat_b0", got_at(0), 32'hFF);
    chk("sat_b1", got_at(1), 32'hFF);
    chk("sat_b2", got_at(2), 32'hFF);

    // random backpressure on random data
    for (int k = 0; k < 2; k++) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < CORR_W; i++) cv[i] = 1'($urandom_range(0, 1));
      it = $urandom_range(0, 400);
      cy = $urandom;
      do_load("bp", it, cy, cv);
      collect("bp", 1'b1, 0, -1);
      compare_msg("bp", 0);
    end

    // stray load during a message
    repeat (2) @(negedge clk);
    for (int i = 0; i < CORR_W; i++) cv[i] = 1'($urandom_range(0, 1));
    do_load("busyload", 32'd42, 32'h0000_7777, cv);
    collect("busyload", 1'b0, 0, 20);
    compare_msg("busyload", 0);
    @(negedge clk);
    chk("busyload_no_restart", 32'(o_output_valid), 32'd0);

    // reset after ten transfers
    for (int i = 0; i < CORR_W; i++) cv[i] = 1'($urandom_range(0, 1));
    do_load("midrst", 32'd9, 32'h0000_0A0B, cv);
    collect("midrst", 1'b0, 10, -1);
    compare_msg("midrst", 10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(o_output_valid), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_load_ready", 32'(o_load_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_quiet", 32'(o_output_valid), 32'd0);

    // full message after the abandoned one
    for (int i = 0; i < CORR_W; i++) cv[i] = 1'($urandom_range(0, 1));
    do_load("after", 32'd200, 32'h0000_FFFF, cv);
    collect("after", 1'b1, 0, -1);
    compare_msg("after", 0);
    chk("after_b0", got_at(0), 32'hC8);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
